// File: rtl/cache_l2_control_if.sv
// Signal bundle between the L2 cache controller, its datapath and the upstream requester.
// The controller uses the slave modport; the environment driving it uses master.
`timescale 1ns/1ps
interface cache_l2_control_if;
    logic       mem_read;
    logic       mem_write;
    logic       hit;
    logic       way;
    logic       lru_out;
    logic [1:0] dirty_out;
    logic       pmem_resp;

    logic       array_read;
    logic       array1_load;
    logic       array2_load;
    logic       lru_load;
    logic       pmdr_load;
    logic       datareadmux_sel;
    logic       datawritemux_sel;
    logic       adaptermux_sel;
    logic       pmemaddrmux_sel;
    logic [1:0] dirty_load;
    logic       mem_resp;
    logic       pmem_read;
    logic       pmem_write;

    modport slave (
        input  mem_read, mem_write, hit, way, lru_out, dirty_out, pmem_resp,
        output array_read, array1_load, array2_load, lru_load, pmdr_load,
               datareadmux_sel, datawritemux_sel, adaptermux_sel, pmemaddrmux_sel,
               dirty_load, mem_resp, pmem_read, pmem_write
    );

    modport master (
        output mem_read, mem_write, hit, way, lru_out, dirty_out, pmem_resp,
        input  array_read, array1_load, array2_load, lru_load, pmdr_load,
               datareadmux_sel, datawritemux_sel, adaptermux_sel, pmemaddrmux_sel,
               dirty_load, mem_resp, pmem_read, pmem_write
    );
endinterface

// File: rtl/cache_l2_control.sv
// Control FSM for a 2-way L2 cache with 256-bit lines: hit service, dirty-victim
// writeback, read fill and line install. Way A = array1 (dirty bit [1]), way B = array2.
`timescale 1ns/1ps
module cache_l2_control (
    input  logic                  clk,
    input  logic                  rst,
    cache_l2_control_if.slave     bus
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        TAG_CHECK = 3'd1,
        WRITEBACK = 3'd2,
        FILL      = 3'd3,
        INSTALL   = 3'd4
    } state_e;

    typedef struct packed {
        logic       array_read;
        logic       array1_load;
        logic       array2_load;
        logic       lru_load;
        logic       pmdr_load;
        logic       datareadmux_sel;
        logic       datawritemux_sel;
        logic       adaptermux_sel;
        logic       pmemaddrmux_sel;
        logic [1:0] dirty_load;
        logic       mem_resp;
        logic       pmem_read;
        logic       pmem_write;
    } ctrl_t;

    state_e state_q, state_d;
    logic   victim_q, victim_d;
    ctrl_t  ctrl, ctrl_out;

    logic is_req, is_write, victim_dirty;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            victim_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            victim_q <= victim_d;
        end
    end

    assign is_req       = bus.mem_read | bus.mem_write;
    assign is_write     = bus.mem_write;
    assign victim_dirty = bus.lru_out ? bus.dirty_out[0] : bus.dirty_out[1];

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        ctrl     = '0;
        state_d  = state_q;
        victim_d = victim_q;

        unique case (state_q)
            IDLE: begin
                ctrl.array_read = 1'b1;
                if (is_req) state_d = TAG_CHECK;
            end

            TAG_CHECK: begin
                ctrl.array_read = 1'b1;
                if (!is_req) begin
                    state_d = IDLE;
                end else if (bus.hit) begin
                    ctrl.lru_load = 1'b1;
                    ctrl.mem_resp = 1'b1;
                    state_d       = IDLE;
                    if (is_write) begin
                        ctrl.datawritemux_sel = 1'b1;
                        ctrl.array1_load      = ~bus.way;
                        ctrl.array2_load      = bus.way;
                        ctrl.dirty_load       = bus.way ? 2'b01 : 2'b10;
                    end else begin
                        ctrl.datareadmux_sel = bus.way;
                        ctrl.adaptermux_sel  = 1'b0;
                    end
                end else begin
                    victim_d = bus.lru_out;
                    if (victim_dirty) state_d = WRITEBACK;
                    else if (is_write) state_d = INSTALL;   // full-line write needs no fetch
                    else               state_d = FILL;
                end
            end

            WRITEBACK: begin
                ctrl.pmem_write      = 1'b1;
                ctrl.pmemaddrmux_sel = 1'b1;
                ctrl.datareadmux_sel = victim_q;
                if (bus.pmem_resp) state_d = is_write ? INSTALL : FILL;
            end

            FILL: begin
                ctrl.pmem_read       = 1'b1;
                ctrl.pmemaddrmux_sel = 1'b0;
                ctrl.pmdr_load       = bus.pmem_resp;
                if (bus.pmem_resp) state_d = INSTALL;
            end

            INSTALL: begin
                // The hit that follows in TAG_CHECK responds and updates the LRU.
                ctrl.array_read       = 1'b1;
                ctrl.datawritemux_sel = is_write;
                ctrl.array1_load      = ~victim_q;
                ctrl.array2_load      = victim_q;
                ctrl.dirty_load       = victim_q ? 2'b01 : 2'b10;
                state_d               = TAG_CHECK;
            end

            default: state_d = IDLE;
        endcase
    end

    // Reset forces every strobe low immediately, abandoning any memory transfer in flight.
    assign ctrl_out = rst ? '0 : ctrl;

    assign bus.array_read       = ctrl_out.array_read;
    assign bus.array1_load      = ctrl_out.array1_load;
    assign bus.array2_load      = ctrl_out.array2_load;
    assign bus.lru_load         = ctrl_out.lru_load;
    assign bus.pmdr_load        = ctrl_out.pmdr_load;
    assign bus.datareadmux_sel  = ctrl_out.datareadmux_sel;
    assign bus.datawritemux_sel = ctrl_out.datawritemux_sel;
    assign bus.adaptermux_sel   = ctrl_out.adaptermux_sel;
    assign bus.pmemaddrmux_sel  = ctrl_out.pmemaddrmux_sel;
    assign bus.dirty_load       = ctrl_out.dirty_load;
    assign bus.mem_resp         = ctrl_out.mem_resp;
    assign bus.pmem_read        = ctrl_out.pmem_read;
    assign bus.pmem_write       = ctrl_out.pmem_write;

endmodule
